// File: rtl/tt_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tt_sweep_checker                                             |
// | Description : Sweeps every input pattern of a small combinational DUT,     |
// |               holds each one for HOLD cycles and checks the DUT output     |
// |               against a truth table. It records the mismatch count, the    |
// |               first failing pattern and, optionally, a per-pattern map.    |
// | Options     : define TT_SWEEP_FAILMAP_EN to build the fail_map register;   |
// |               when it is undefined, fail_map is tied to zero.              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tt_sweep_checker #(
  parameter int                 N_IN  = 3,
  parameter logic [2**N_IN-1:0] TRUTH = 8'b1001_0110,
  parameter int                 HOLD  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 dut_y,
  output logic [N_IN-1:0]      pattern,
  output logic                 expected,
  output logic                 sample,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        err_count,
  output logic [N_IN-1:0]      first_err,
  output logic [2**N_IN-1:0]   fail_map
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Hold counter value that marks the sample cycle of a pattern.
  localparam logic [7:0]      c_HOLD_LAST = 8'(HOLD - 1);
  localparam logic [N_IN-1:0] c_PAT_ONE   = N_IN'(1);
  localparam logic [N_IN:0]   c_ERR_ONE   = (N_IN + 1)'(1);

  state_t          state_q;
  logic [N_IN-1:0] pattern_q;
  logic [N_IN-1:0] pattern_d;
  logic [7:0]      hold_q;
  logic [7:0]      hold_d;
  logic [N_IN:0]   err_q;
  logic [N_IN:0]   err_d;
  logic [N_IN-1:0] first_err_q;
  logic            sample_q;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic            mismatch;

  assign expected  = TRUTH[pattern_q];
  assign mismatch  = dut_y ^ expected;
  assign pattern_d = pattern_q + c_PAT_ONE;
  assign hold_d    = hold_q + 8'd1;
  assign err_d     = err_q + c_ERR_ONE;

  // Sweep controller: pattern stepping, hold timing, error tally and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pattern_q   <= '0;
      hold_q      <= '0;
      err_q       <= '0;
      first_err_q <= '0;
      sample_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_SWEEP;
            pattern_q   <= '0;
            hold_q      <= '0;
            err_q       <= '0;
            first_err_q <= '0;
            // With HOLD=1 the very first sweep cycle is already a sample cycle.
            sample_q    <= (c_HOLD_LAST == 8'd0);
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
          end
        end
        S_SWEEP: begin
          if (sample_q) begin
            if (mismatch) begin
              err_q <= err_d;
              if (err_q == '0) begin
                first_err_q <= pattern_q;
              end
            end
            hold_q <= '0;
            if (&pattern_q) begin
              // Last pattern checked: pattern stays at all-ones in DONE.
              state_q  <= S_DONE;
              sample_q <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
              pass_q   <= (err_q == '0) && !mismatch;
            end else begin
              pattern_q <= pattern_d;
              sample_q  <= (c_HOLD_LAST == 8'd0);
            end
          end else begin
            hold_q   <= hold_d;
            sample_q <= (hold_d == c_HOLD_LAST);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

`ifdef TT_SWEEP_FAILMAP_EN
  logic [2**N_IN-1:0] fail_map_q;

  // Per-pattern failure map, cleared on an accepted start and set on each mismatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_map_q <= '0;
    end else if ((state_q != S_SWEEP) && start) begin
      fail_map_q <= '0;
    end else if ((state_q == S_SWEEP) && sample_q && mismatch) begin
      fail_map_q[pattern_q] <= 1'b1;
    end
  end

  assign fail_map = fail_map_q;
`else
  assign fail_map = '0;
`endif

  assign pattern   = pattern_q;
  assign sample    = sample_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign first_err = first_err_q;

endmodule
`default_nettype wire

// File: tb/tb_tt_sweep_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tt_sweep_checker                                          |
// | Description : Scoreboard bench for tt_sweep_checker (HOLD=1 and HOLD=3).   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_tt_sweep_checker;

  localparam logic [7:0] TRUTH = 8'b1001_0110;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [7:0] inv_mask = 8'h00;

  logic       dut_y1, expected1, sample1, busy1, done1, pass1;
  logic [2:0] pattern1, first1;
  logic [3:0] err1;
  logic [7:0] map1;

  logic       dut_y3, expected3, sample3, busy3, done3, pass3;
  logic [2:0] pattern3, first3;
  logic [3:0] err3;
  logic [7:0] map3;

  assign dut_y1 = expected1 ^ inv_mask[pattern1];
  assign dut_y3 = expected3;

  always #5 clk = ~clk;

  tt_sweep_checker #(.N_IN(3), .TRUTH(TRUTH), .HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_y(dut_y1),
    .pattern(pattern1), .expected(expected1), .sample(sample1), .busy(busy1),
    .done(done1), .pass(pass1), .err_count(err1), .first_err(first1), .fail_map(map1)
  );

  tt_sweep_checker #(.N_IN(3), .TRUTH(TRUTH), .HOLD(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_y(dut_y3),
    .pattern(pattern3), .expected(expected3), .sample(sample3), .busy(busy3),
    .done(done3), .pass(pass3), .err_count(err3), .first_err(first3), .fail_map(map3)
  );

  typedef struct packed {
    logic [3:0] err;
    logic [2:0] first;
    logic [7:0] map;
    logic       pass;
  } res_t;

  res_t       q_res[$];
  logic [2:0] q_pat[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic       done1_prev = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected per-sample patterns and end-of-sweep results for a given inversion mask.
  task automatic push_sweep(input logic [7:0] mask);
    res_t r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      q_pat.push_back(3'(k));
      if (mask[k]) begin
        if (r.err == 4'd0) r.first = 3'(k);
        r.err    = r.err + 4'd1;
        r.map[k] = 1'b1;
      end
    end
`ifndef TT_SWEEP_FAILMAP_EN
    r.map = 8'h00;
`endif
    r.pass = (r.err == 4'd0);
    q_res.push_back(r);
  endtask

  // Monitor for the HOLD=1 instance: compare samples and sweep results with the scoreboard.
  always @(negedge clk) begin
    logic [2:0] p;
    res_t       r;
    if (sample1) begin
      if (q_pat.size() == 0) begin
        check_value("unexpected_sample", 32'd1, 32'd0);
      end else begin
        p = q_pat.pop_front();
        check_value("sample_pattern", 32'(pattern1), 32'(p));
        check_value("sample_expected", 32'(expected1), 32'(TRUTH[p]));
      end
    end
    if (done1 && !done1_prev) begin
      if (q_res.size() == 0) begin
        check_value("unexpected_done", 32'd1, 32'd0);
      end else begin
        r = q_res.pop_front();
        check_value("err_count", 32'(err1), 32'(r.err));
        check_value("first_err", 32'(first1), 32'(r.first));
        check_value("fail_map", 32'(map1), 32'(r.map));
        check_value("pass", 32'(pass1), 32'(r.pass));
        check_value("done_pattern", 32'(pattern1), 32'd7);
      end
    end
    check_value("busy_and_done", 32'(busy1 & done1), 32'd0);
    check_value("pass_outside_done", 32'(pass1 & ~done1), 32'd0);
    done1_prev = done1;
  end

  // Run one sweep on the HOLD=1 instance; poke re-asserts start at that busy cycle.
  task automatic run1(input logic [7:0] mask, input int poke);
    int nb = 0;
    int guard = 0;
    inv_mask = mask;
    push_sweep(mask);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    while (!done1 && guard < 200) begin
      if (busy1) nb++;
      guard++;
      start1 = (nb == poke);
      @(negedge clk);
    end
    start1 = 1'b0;
    check_value("sweep1_timeout", 32'(guard < 200), 32'd1);
    check_value("sweep1_cycles", 32'(nb), 32'd8);
  endtask

  task automatic check_zero1(input string tag);
    check_value({tag, "_pattern"}, 32'(pattern1), 32'd0);
    check_value({tag, "_sample"}, 32'(sample1), 32'd0);
    check_value({tag, "_busy"}, 32'(busy1), 32'd0);
    check_value({tag, "_done"}, 32'(done1), 32'd0);
    check_value({tag, "_pass"}, 32'(pass1), 32'd0);
    check_value({tag, "_err"}, 32'(err1), 32'd0);
    check_value({tag, "_first"}, 32'(first1), 32'd0);
    check_value({tag, "_map"}, 32'(map1), 32'd0);
  endtask

  initial begin
    int nb;
    int guard;

    // Reset state
    repeat (2) @(negedge clk);
    check_zero1("rst");
    check_value("rst3_busy", 32'(busy3), 32'd0);
    check_value("rst3_err", 32'(err3), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_value("idle_no_start", 32'(busy1), 32'd0);

    // Clean loopback, single mismatch at pattern 5, all inverted
    run1(8'h00, -1);
    run1(8'h20, -1);
    run1(8'hFF, -1);

    // Results held while sitting in DONE
    repeat (3) @(negedge clk);
    check_value("hold_done", 32'(done1), 32'd1);
    check_value("hold_err", 32'(err1), 32'd8);
    check_value("hold_first", 32'(first1), 32'd0);
    check_value("hold_pass", 32'(pass1), 32'd0);

    // Start in DONE clears the tally; start during SWEEP is ignored
    run1(8'h20, 3);

    // Reset mid-sweep at pattern 4
    inv_mask = 8'h00;
    push_sweep(8'h00);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    guard = 0;
    while (pattern1 != 3'd4 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    check_value("reach_pat4", 32'(pattern1), 32'd4);
    #2 rst_n = 1'b0;
    #1 check_zero1("abort");
    @(negedge clk);
    q_pat.delete();
    q_res.delete();
    check_zero1("abort_hold");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_value("post_rst_idle", 32'(busy1), 32'd0);
    run1(8'h00, -1);

    // HOLD=3: sample every third busy cycle, 24 busy cycles, done on the 25th
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    nb = 0;
    guard = 0;
    while (!done3 && guard < 200) begin
      if (busy3) begin
        check_value("h3_sample", 32'(sample3), 32'((nb % 3) == 2));
        check_value("h3_pattern", 32'(pattern3), 32'(nb / 3));
        nb++;
      end
      guard++;
      @(negedge clk);
    end
    check_value("h3_timeout", 32'(guard < 200), 32'd1);
    check_value("h3_busy_cycles", 32'(nb), 32'd24);
    check_value("h3_done", 32'(done3), 32'd1);
    check_value("h3_busy_off", 32'(busy3), 32'd0);
    check_value("h3_pass", 32'(pass3), 32'd1);
    check_value("h3_err", 32'(err3), 32'd0);

    repeat (2) @(negedge clk);
    check_value("sb_pat_empty", 32'(q_pat.size()), 32'd0);
    check_value("sb_res_empty", 32'(q_res.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
